// File: rtl/uart_row_writer.sv
// uart_row_writer: snapshots a received UART row and streams it pixel by pixel into the frame buffer
module uart_row_writer #(
    parameter int WIDTH  = 640,
    parameter int HEIGHT = 480,
    parameter int BPP    = 3,
    parameter int ADDR_W = 19
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 done,
    input  logic [8:0]           row,
    input  logic [BPP*WIDTH-1:0] uart_data,
    input  logic                 fb_ready,
    output logic                 fb_we,
    output logic [ADDR_W-1:0]    fb_addr,
    output logic [BPP-1:0]       fb_wdata,
    output logic                 busy,
    output logic                 row_done,
    output logic                 frame_done,
    output logic                 row_err,
    output logic                 overrun
);
    localparam int COL_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic {IDLE, WRITE} state_t;

    state_t               state, state_d;
    logic                 done_q, last_row;
    logic [COL_W-1:0]     col;
    logic [BPP*WIDTH-1:0] shadow;
    logic                 strobe, row_ok, start, accept, last_px;

    assign strobe   = done & ~done_q;
    assign row_ok   = 32'(row) < HEIGHT;
    assign start    = (state == IDLE) & strobe & row_ok;
    assign accept   = (state == WRITE) & fb_ready;
    assign last_px  = accept & (col == COL_W'(WIDTH - 1));
    assign fb_we    = state == WRITE;
    assign busy     = state == WRITE;
    assign fb_wdata = shadow[BPP-1:0];

    // state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_d;
    end

    // next state: enter WRITE on a legal strobe, leave once the last pixel is accepted
    always_comb begin
        state_d = state;
        state_d = (state == IDLE) ? (start ? WRITE : IDLE) : (last_px ? IDLE : WRITE);
    end

    // datapath: snapshot, address/column stepping on each accepted pixel, status pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            done_q     <= 1'b0;
            last_row   <= 1'b0;
            col        <= '0;
            shadow     <= '0;
            fb_addr    <= '0;
            row_done   <= 1'b0;
            frame_done <= 1'b0;
            row_err    <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            done_q     <= done;
            row_done   <= last_px;
            frame_done <= last_px & last_row;
            row_err    <= (state == IDLE) & strobe & ~row_ok;
            overrun    <= (state == WRITE) & strobe;
            if (start) begin
                shadow   <= uart_data;
                fb_addr  <= ADDR_W'(row) * ADDR_W'(WIDTH);
                col      <= '0;
                last_row <= 32'(row) == HEIGHT - 1;
            end else if (accept) begin
                shadow  <= shadow >> BPP;
                fb_addr <= fb_addr + ADDR_W'(1);
                col     <= col + COL_W'(1);
            end
        end
    end
endmodule
